// File: rtl/ethernet_perf_counter_snapshot_if.sv
// rtl/ethernet_perf_counter_snapshot_if.sv - management read port of the counter snapshot block
interface ethernet_perf_counter_snapshot_if;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/ethernet_perf_counter_snapshot.sv
// rtl/ethernet_perf_counter_snapshot.sv - atomic snapshot and per-interval deltas of five MAC counters
module ethernet_perf_counter_snapshot #(
  parameter int unsigned AUTO_PERIOD = 125000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] rx_frames,
  input  logic [63:0] rx_crc_err,
  input  logic [63:0] rx_bytes,
  input  logic [63:0] tx_frames,
  input  logic [63:0] tx_bytes,
  input  logic        snap_req,
  input  logic        clear_req,
  output logic        snap_done,
  output logic        busy,
  output logic [15:0] snap_seq,
  ethernet_perf_counter_snapshot_if.slave rd
);

  localparam int unsigned   TW     = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam bit            T_EN   = (AUTO_PERIOD != 0);
  localparam logic [TW-1:0] T_LAST = (AUTO_PERIOD > 0) ? TW'(AUTO_PERIOD - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DELTA,
    S_DONE
  } state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [TW-1:0] timer;
  logic          snap_pend;
  logic          clear_pend;

  logic [63:0] cur   [5];
  logic [63:0] base  [5];
  logic [63:0] delta [5];
  logic [63:0] live  [5];

  logic tick;
  logic req_any;
  logic clear_now;
  logic start;

  assign live[0] = rx_frames;
  assign live[1] = rx_crc_err;
  assign live[2] = rx_bytes;
  assign live[3] = tx_frames;
  assign live[4] = tx_bytes;

  assign tick      = T_EN && (timer == T_LAST);
  assign req_any   = snap_pend | snap_req | tick;
  assign clear_now = clear_pend | clear_req;
  assign start     = (state == S_IDLE) && !clear_now && req_any;

  // Reload on every CAPTURE entry so a manual snapshot restarts the auto interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (start || tick) begin
      timer <= '0;
    end else if (T_EN) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      snap_pend  <= 1'b0;
      clear_pend <= 1'b0;
      snap_done  <= 1'b0;
      busy       <= 1'b0;
      snap_seq   <= '0;
      for (int i = 0; i < 5; i++) begin
        cur[i]   <= '0;
        base[i]  <= '0;
        delta[i] <= '0;
      end
    end else begin
      snap_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear_now) begin
            // Clear wins this cycle; any snapshot request stays pending for the next one.
            clear_pend <= 1'b0;
            snap_pend  <= req_any;
            snap_seq   <= '0;
            for (int i = 0; i < 5; i++) begin
              cur[i]   <= '0;
              base[i]  <= '0;
              delta[i] <= '0;
            end
          end else if (req_any) begin
            // All five inputs land on one edge, so cur[] is a coherent snapshot in CAPTURE.
            snap_pend <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CAPTURE;
            for (int i = 0; i < 5; i++) begin
              cur[i] <= live[i];
            end
          end
        end
        S_CAPTURE: begin
          idx   <= '0;
          state <= S_DELTA;
        end
        S_DELTA: begin
          // A counter that went backwards was reset upstream; its new value is the delta.
          delta[idx] <= (cur[idx] >= base[idx]) ? (cur[idx] - base[idx]) : cur[idx];
          base[idx]  <= cur[idx];
          if (idx == 3'd4) begin
            busy      <= 1'b0;
            snap_done <= 1'b1;
            snap_seq  <= snap_seq + 16'd1;
            state     <= S_DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (state != S_IDLE) begin
        snap_pend  <= snap_pend | snap_req | tick;
        clear_pend <= clear_pend | clear_req;
      end
    end
  end

  logic [31:0] rd_word;
  logic [2:0]  rd_sel;

  assign rd_sel = rd.rd_addr[4:2];

  always_comb begin
    rd_word = '0;
    if (rd.rd_addr < 5'd20) begin
      case (rd.rd_addr[1:0])
        2'd0:    rd_word = cur[rd_sel][31:0];
        2'd1:    rd_word = cur[rd_sel][63:32];
        2'd2:    rd_word = delta[rd_sel][31:0];
        default: rd_word = delta[rd_sel][63:32];
      endcase
    end else if (rd.rd_addr == 5'd20) begin
      rd_word = {busy, 15'd0, snap_seq};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
    end else begin
      rd.rd_valid <= rd.rd_en;
      if (rd.rd_en) begin
        rd.rd_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_ethernet_perf_counter_snapshot.sv
// tb/tb_ethernet_perf_counter_snapshot.sv - self-checking bench for ethernet_perf_counter_snapshot
module tb_ethernet_perf_counter_snapshot;
  localparam int P = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] rx_frames = '0, rx_crc_err = '0, rx_bytes = '0, tx_frames = '0, tx_bytes = '0;
  logic        snap_req = 1'b0, clear_req = 1'b0;
  logic        snap_done, busy;
  logic [15:0] snap_seq;
  int          cyc = 0;
  int          n_tests = 0, n_fail = 0;

  ethernet_perf_counter_snapshot_if ifc ();

  ethernet_perf_counter_snapshot #(.AUTO_PERIOD(P)) dut (
    .clk(clk), .rst(rst),
    .rx_frames(rx_frames), .rx_crc_err(rx_crc_err), .rx_bytes(rx_bytes),
    .tx_frames(tx_frames), .tx_bytes(tx_bytes),
    .snap_req(snap_req), .clear_req(clear_req),
    .snap_done(snap_done), .busy(busy), .snap_seq(snap_seq),
    .rd(ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a snapshot accepted at cycle N shows busy N+1..N+6 and completes as a whole at N+7.
  logic [63:0] m_cur [5], m_delta [5], m_base [5], m_cap [5], lv [5];
  logic [15:0] m_seq;
  int          start_c, done_c, next_tick;
  bit          pend, cpend, e_rv, e_known, rst_seen = 0, e_busy, tick;
  logic [31:0] e_rd;

  function automatic logic [31:0] mword(input int a, input bit b);
    logic [63:0] v;
    if (a < 20) begin
      v = (a % 4 < 2) ? m_cur[a / 4] : m_delta[a / 4];
      return (a % 2 == 0) ? v[31:0] : v[63:32];
    end
    if (a == 20) return {b, 15'd0, m_seq};
    return 32'd0;
  endfunction

  always @(negedge clk) begin
    lv[0] = rx_frames; lv[1] = rx_crc_err; lv[2] = rx_bytes; lv[3] = tx_frames; lv[4] = tx_bytes;
    if (rst) begin
      rst_seen = 1; m_seq = 0; pend = 0; cpend = 0; e_rv = 0; e_known = 0;
      start_c = -100; done_c = -100; next_tick = cyc + P;
      for (int i = 0; i < 5; i++) begin m_cur[i] = 0; m_delta[i] = 0; m_base[i] = 0; end
    end else if (rst_seen) begin
      if (cyc == done_c) begin
        for (int i = 0; i < 5; i++) begin
          m_delta[i] = (m_cap[i] >= m_base[i]) ? m_cap[i] - m_base[i] : m_cap[i];
          m_base[i] = m_cap[i];
          m_cur[i] = m_cap[i];
        end
        m_seq = m_seq + 1;
      end
      e_busy = (cyc > start_c) && (cyc < done_c);
      chk("busy", busy, e_busy);
      chk("snap_done", snap_done, cyc == done_c);
      chk("snap_seq", snap_seq, m_seq);
      chk("rd_valid", ifc.rd_valid, e_rv);
      if (e_rv && e_known) chk("rd_data", ifc.rd_data, e_rd);
      e_rv = ifc.rd_en;
      if (ifc.rd_en) begin
        e_known = (ifc.rd_addr >= 20) || !e_busy;
        e_rd = mword(int'(ifc.rd_addr), e_busy);
      end
      tick = (cyc == next_tick);
      if (tick) next_tick = cyc + P;
      if (cyc > done_c) begin
        if (cpend || clear_req) begin
          cpend = 0; pend = pend || snap_req || tick; m_seq = 0;
          for (int i = 0; i < 5; i++) begin m_cur[i] = 0; m_delta[i] = 0; m_base[i] = 0; end
        end else if (pend || snap_req || tick) begin
          for (int i = 0; i < 5; i++) m_cap[i] = lv[i];
          pend = 0; start_c = cyc; done_c = cyc + 7; next_tick = cyc + P;
        end
      end else begin
        pend = pend || snap_req || tick;
        cpend = cpend || clear_req;
      end
    end
  end

  task automatic pulse_snap(output int t);
    @(posedge clk); #1 snap_req = 1; t = cyc;
    @(posedge clk); #1 snap_req = 0;
  endtask

  task automatic wait_done(input int lim, output int dc);
    dc = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (snap_done) begin dc = cyc; break; end
    end
    if (dc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL wait_done: no snap_done within %0d cycles", lim);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #1 ifc.rd_en = 1; ifc.rd_addr = a;
    @(posedge clk); #1 ifc.rd_en = 0;
    @(negedge clk);
    chk("rd_valid_on", ifc.rd_valid, 1);
    d = ifc.rd_data;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, dc, d1, d2, m, r, n, last;
    logic [31:0] d;
    ifc.rd_en = 0; ifc.rd_addr = '0;
    rx_frames = 1; rx_crc_err = 2; rx_bytes = 1000; tx_frames = 4; tx_bytes = 5;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_seq", snap_seq, 0);
    chk("reset_busy", busy, 0);

    // First snapshot: 7-cycle latency, cur and delta both equal the inputs.
    repeat (8) @(posedge clk);
    pulse_snap(t); wait_done(20, dc);
    chk("t1_latency", dc - t, 7);
    rd(8, d);  chk("t1_cur_lo", d, 1000);
    rd(9, d);  chk("t1_cur_hi", d, 0);
    rd(10, d); chk("t1_delta", d, 1000);
    rd(20, d); chk("t1_status", d, 1);

    @(posedge clk); #1 rx_bytes = 1500;
    pulse_snap(t); wait_done(20, dc);
    rd(10, d); chk("t2_delta", d, 500);
    rd(8, d);  chk("t2_cur", d, 1500);
    rd(20, d); chk("t2_status", d, 2);

    @(posedge clk); #1 tx_bytes = 64'h1_0000_0005;
    pulse_snap(t); wait_done(20, dc);
    rd(16, d); chk("t3_cur_lo", d, 5);
    rd(17, d); chk("t3_cur_hi", d, 1);
    @(posedge clk); #1 tx_bytes = 3;
    pulse_snap(t); wait_done(20, dc);
    rd(18, d); chk("t3_wrap_delta_lo", d, 3);
    rd(19, d); chk("t3_wrap_delta_hi", d, 0);
    rd(16, d); chk("t3_wrap_cur", d, 3);

    // Requests at t, t+2, t+4, t+6 and a clear at t+3 while busy.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1 snap_req = (k % 2 == 0); clear_req = (k == 3);
      if (k == 0) t = cyc;
    end
    n = 0; last = -1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (snap_done) begin n++; last = cyc; end
    end
    chk("t4_done_count", n, 2);
    chk("t4_second_done", last - t, 16);
    rd(2, d);  chk("t4_delta_after_clear", d, 1);
    rd(10, d); chk("t4_rxb_delta", d, 1500);
    rd(20, d); chk("t4_status", d, 1);
    @(posedge clk); #1 clear_req = 1;
    @(posedge clk); #1 clear_req = 0;
    for (int a = 0; a <= 20; a++) begin
      rd(5'(a), d); chk($sformatf("t4_clr_a%0d", a), d, 0);
    end

    // Reset during DELTA index 2 aborts the snapshot.
    @(posedge clk); #1 rx_frames = 77;
    pulse_snap(t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1; r = cyc;
    @(posedge clk); #1 rst = 0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (snap_done) n++;
    end
    chk("t6_no_done", n, 0);
    rd(20, d); chk("t6_status", d, 0);
    rd(0, d);  chk("t6_cur0", d, 0);
    rd(10, d); chk("t6_delta2", d, 0);
    rd(25, d); chk("t6_addr25", d, 0);
    @(negedge clk);
    chk("rd_valid_off", ifc.rd_valid, 0);

    // Auto timer from the reset above, then a manual request at timer value 50.
    wait_done(200, d1);
    chk("t5_first_auto", d1 - r, 107);
    wait_done(150, d2);
    chk("t5_period", d2 - d1, 100);
    repeat (44) @(posedge clk);
    #1 snap_req = 1; m = cyc;
    @(posedge clk); #1 snap_req = 0;
    wait_done(20, dc);
    chk("t5_manual_latency", dc - m, 7);
    wait_done(150, d1);
    chk("t5_after_manual", d1 - dc, 100);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
